// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin pick instead of
// fixed priority).
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Expand a requester index into its one-hot grant pattern.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational priority pick. The search begins at index `start` and walks
// downward (start, start-1, ...) modulo N_REQ; the first set request wins.
// With start tied to 3 this is plain fixed priority 3 > 2 > 1 > 0.
module arb_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic [N_REQ-1:0] win,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  // cand_idx[r] is the requester examined at search rank r.
  logic [ID_W-1:0] cand_idx [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = start - ID_W'(gi);
  end

  // Scan from the last rank to the first so the earliest-ranked hit overwrites.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int r = N_REQ - 1; r >= 0; r--) begin
      if (req[cand_idx[r]]) begin
        id  = cand_idx[r];
        any = 1'b1;
      end
    end
    win = any ? id_to_onehot(id) : '0;
  end

endmodule

// File: rtl/req_arbiter_4.sv
// Four-requester arbiter with registered one-hot grant, hold timeout and a
// one-shot mask against the most recently preempted owner.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects a round-robin pick
// (search starts one past the last winner); undefined gives fixed priority.
module req_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  // A zero MAX_HOLD still needs a legal one-bit counter; it simply never moves.
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LOAD = (MAX_HOLD > 0) ? CNT_W'(1) : '0;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] mask_q, mask_d;

  logic [N_REQ-1:0] masked_req, arb_req;
  logic [ID_W-1:0]  start_idx;
  logic [N_REQ-1:0] pick_win;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             owner_req, other_req;

  // The mask only steers the pick when someone else is asking; a lone
  // masked requester is still served so it can never starve.
  assign masked_req = req & ~mask_q;
  assign arb_req    = (|masked_req) ? masked_req : req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q + ID_W'(1);

  // Remember the last winner so the next search starts just past it.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ARB_IDLE && pick_any) ptr_d = pick_id;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign start_idx = ID_W'(N_REQ - 1);
`endif

  arb_pick u_pick (
    .req   (arb_req),
    .start (start_idx),
    .win   (pick_win),
    .id    (pick_id),
    .any   (pick_any)
  );

  assign owner_req = req[gnt_id_q];
  assign other_req = |(req & ~gnt_q);

  // Next-state logic: arbitrate in IDLE, hold/release/preempt in GRANT.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    mask_d     = mask_q;
    case (state_q)
      ARB_IDLE: begin
        // The mask is consumed by this arbitration whether or not anyone wins.
        mask_d = '0;
        if (pick_any) begin
          state_d    = ARB_GRANT;
          gnt_d      = pick_win;
          gnt_id_d   = pick_id;
          hold_cnt_d = CNT_LOAD;
        end
      end
      ARB_GRANT: begin
        if (!owner_req) begin
          // Release wins over a coincident timeout: no pulse, no mask.
          state_d    = ARB_IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == CNT_MAX) && other_req) begin
          state_d    = ARB_IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
          preempt_d  = 1'b1;
          mask_d     = gnt_q;
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        gnt_d      = '0;
        gnt_id_d   = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State, counter, mask and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      preempt_q  <= preempt_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Scoreboard bench for req_arbiter_4 (MAX_HOLD = 4). Each directed vector
// drives req at a falling edge and queues the outputs expected after the
// following rising edge; a monitor pops and compares just after that edge.
module tb_req_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  typedef struct packed {
    logic [15:0] tag;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        pre;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   vec_n    = 0;

  req_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s vec%0d got %b want %b", name, tag, got, want);
    end
  endtask

  // Drive one request vector at a falling edge and queue the expected result.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i, input logic p);
    exp_t e;
    req   = r;
    e.tag = 16'(vec_n);
    e.gnt = g;
    e.id  = i;
    e.pre = p;
    exp_q.push_back(e);
    $display("vec%0d req=%b expect gnt=%b id=%0d preempt=%b", vec_n, r, g, i, p);
    vec_n++;
    @(negedge clk);
  endtask

  // Monitor: compare the DUT outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",       int'(e.tag), gnt,             e.gnt);
        chk("gnt_id",    int'(e.tag), {2'b00, gnt_id}, {2'b00, e.id});
        chk("gnt_valid", int'(e.tag), {3'b000, gnt_valid}, {3'b000, |e.gnt});
        chk("preempt",   int'(e.tag), {3'b000, preempt},   {3'b000, e.pre});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d vectors pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_gnt",       -1, gnt,             4'b0000);
    chk("reset_gnt_id",    -1, {2'b00, gnt_id}, 4'b0000);
    chk("reset_gnt_valid", -1, {3'b000, gnt_valid}, 4'b0000);
    chk("reset_preempt",   -1, {3'b000, preempt},   4'b0000);
    rst_n = 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin from ptr=0, each owner releases after one cycle.
    step(4'b1111, 4'b0010, 2'd1, 1'b0);
    step(4'b1101, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b0);
    step(4'b1011, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b0);
    step(4'b0111, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1110, 4'b0000, 2'd0, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
`else
    // Reset in the middle of a grant clears outputs at once, then regrants.
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt",       -2, gnt, 4'b0000);
    chk("async_rst_gnt_valid", -2, {3'b000, gnt_valid}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Fixed priority, release, one idle cycle, then the lower requester.
    step(4'b0101, 4'b0100, 2'd2, 1'b0);
    step(4'b0101, 4'b0100, 2'd2, 1'b0);
    step(4'b0001, 4'b0000, 2'd0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Timeout: 3 holds 4 cycles, preempted, masked; then 0 is preempted too.
    repeat (4) step(4'b1001, 4'b1000, 2'd3, 1'b0);
    step(4'b1001, 4'b0000, 2'd0, 1'b1);
    repeat (4) step(4'b1001, 4'b0001, 2'd0, 1'b0);
    step(4'b1001, 4'b0000, 2'd0, 1'b1);
    step(4'b1001, 4'b1000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Sole requester is never preempted.
    repeat (20) step(4'b0010, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // Release on the edge where the timeout would fire: no pulse, no mask.
    repeat (4) step(4'b0011, 4'b0010, 2'd1, 1'b0);
    step(4'b0001, 4'b0000, 2'd0, 1'b0);
    step(4'b0011, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
`endif

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter_4.md
# req_arbiter_4

Four-requester arbiter sharing one downstream resource (bus slot, encoder datapath, shared register port) between requesters in the DSD lab designs. It samples a 4-bit request vector and issues a registered one-hot grant plus its encoded index and valid flag. It holds the grant until the owner releases it or a hold timeout preempts it. Fixed priority is the baseline; round-robin is a compile-time option.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before preemption when other requests are pending. 0 disables the timeout.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input 4: request vector. `req[3]` is highest fixed priority. A requester holds its bit high for as long as it needs the resource.
- `gnt` output 4: registered one-hot grant, or 0.
- `gnt_id` output 2: encoded index of the granted requester. 0 when no grant.
- `gnt_valid` output 1: equals `|gnt`.
- `preempt` output 1: one-cycle pulse on the cycle the grant is withdrawn by timeout.

## Operation
- State machine with two states:
  - IDLE: no grant. If `req` is not 0 (after masking), pick a winner and go to GRANT at the next edge with `gnt` set.
  - GRANT: owner holds the grant. Leave on release or on timeout.
- Fixed-priority pick: highest set bit of the masked `req` (3 > 2 > 1 > 0).
- Mask: the requester preempted in the previous GRANT is excluded from the next arbitration only. If it is the sole requester, it is still granted; the mask never starves.
- `hold_cnt` is a counter of width `$clog2(MAX_HOLD+1)`:
  - Loaded with 1 on the grant edge.
  - Increments each GRANT cycle.
  - Saturates at `MAX_HOLD`.
- Release: the owner's `req` bit is low at a clock edge. At that edge `gnt` goes to 0 and the state goes to IDLE.
- Timeout: `MAX_HOLD` is not 0, `hold_cnt == MAX_HOLD`, and any other `req` bit is high. At that edge:
  - `gnt` goes to 0, state goes to IDLE, `preempt` pulses.
  - The owner's index is latched into the mask.
- Timeout with no other request pending: the grant is kept and `hold_cnt` stays saturated.
- Release and timeout at the same edge: treated as a release. No `preempt`, no mask.
- Requests from non-owners during GRANT are ignored until IDLE. No queueing.

## Timing
- Reset, asynchronous and immediate:
  - `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `preempt`=0.
  - State IDLE, `hold_cnt`=0, mask=0, round-robin pointer=0.
- Grant latency: `req` high before edge N gives `gnt` high after edge N.
- Release latency: `req` low before edge M gives `gnt` low after edge M.
- Turnaround: every grant change passes through one IDLE cycle. The earliest next grant is after edge M+1, so there are never two owners and never back-to-back grants to different requesters.
- A grant lasts at most `MAX_HOLD` cycles while others wait.
- `rst_n` low mid-grant: all outputs clear asynchronously. After release of reset, arbitration restarts from IDLE with no memory of the prior owner.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: the pick is round-robin.
  - Search starts at `(ptr+1) mod 4`, then wraps downward through the remaining indices.
  - `ptr` updates to the winner index on each grant edge.
  - Mask logic still applies.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority as above. No `ptr` register exists.

## Structure
- Package `arb_pkg` holds:
  - `N_REQ` = 4 and `ID_W` = 2.
  - State enum `arb_state_t` (`ARB_IDLE`, `ARB_GRANT`).
- Sub-module `arb_pick`: a combinational priority pick with inputs masked `req[3:0]` and rotate start index `[1:0]`. Outputs are a one-hot winner, `id`, and `any`. Fixed-priority mode ties the start to 3.
- The top module holds the FSM, `hold_cnt`, mask, `ptr` and the output registers.

## Test plan
- Reset mid-grant: `req`=4'b0100 granted, assert `rst_n`=0 between edges -> `gnt`=0 and `gnt_valid`=0 immediately. After reset release, with `req` still 4'b0100, `gnt`=4'b0100 one edge later.
- Fixed priority: `req`=4'b0101 -> after 1 edge `gnt`=4'b0100, `gnt_id`=2. Drop `req[2]` -> `gnt`=0 for 1 cycle, then `gnt`=4'b0001, `gnt_id`=0.
- Timeout: `MAX_HOLD`=4, `req`=4'b1001 held -> `gnt`=4'b1000 for exactly 4 cycles, `preempt` pulse, 1 IDLE cycle, then `gnt`=4'b0001.
- Sole requester at timeout: `req`=4'b0010 only, held for 20 cycles -> `gnt`=4'b0010 continuous, `preempt` never asserted.
- Simultaneous release and timeout: `MAX_HOLD`=3, owner drops `req` on its 3rd grant cycle while another requests -> `preempt`=0, and the next grant follows normal priority with no mask.
- Round robin (`ARB_ROUND_ROBIN_EN`): `req`=4'b1111, each owner releases after 1 cycle -> grant order is 1, 2, 3, 0, 1, starting with `ptr`=0.
